// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the RF write arbiter and by ID.
// Contents: register-file widths, the operand register indices that UART bytes
// are written to, and the state encoding of the arbiter FSM.
package cpu_pkg;
  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  // UART operand pair destinations (ID reads these after uart_signal)
  localparam logic [RF_AW-1:0] OPND1_REG = 5'd4;
  localparam logic [RF_AW-1:0] OPND2_REG = 5'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_STALL = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle around the RF write arbiter.
// UART rx side : rx_valid, rx_data
// WB side      : wb_we, wb_addr, wb_data
// RF side      : rf_we, rf_addr, rf_data
// ID / hazard  : uart_flag, uart_signal, stall_req, rx_overrun
// Modports: slave = the arbiter, master = the surrounding pipeline.
interface rf_write_arbiter_if;
  import cpu_pkg::*;

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             wb_we;
  logic [RF_AW-1:0] wb_addr;
  logic [RF_DW-1:0] wb_data;
  logic             rf_we;
  logic [RF_AW-1:0] rf_addr;
  logic [RF_DW-1:0] rf_data;
  logic             uart_flag;
  logic             uart_signal;
  logic             stall_req;
  logic             rx_overrun;

  modport slave (
    input  rx_valid, rx_data, wb_we, wb_addr, wb_data,
    output rf_we, rf_addr, rf_data, uart_flag, uart_signal, stall_req, rx_overrun
  );

  modport master (
    output rx_valid, rx_data, wb_we, wb_addr, wb_data,
    input  rf_we, rf_addr, rf_data, uart_flag, uart_signal, stall_req, rx_overrun
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO (DEPTH x W), first-word fall-through head.
// Ports: clk, rst_n (async low), push/din, pop/dout, full, empty, count.
// A push while full is accepted when a pop happens in the same cycle.
// Pops on an empty FIFO are ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // payload storage needs no reset; only the pointers/count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between WB and the UART rx path.
// WB always wins; UART bytes queue in a FIFO and drain into OPND1_REG/OPND2_REG
// (alternating) on cycles where WB does not write. If queued data starves too
// long or the FIFO nears full, stall_req asks fetch to stall so bubbles reach WB.
// Ports: clk, rst_n (async low), bus (rf_write_arbiter_if.slave).
// Optional: `RF_ARB_STATS_EN adds stat_overruns / stat_stalls (16-bit, saturating).
module rf_write_arbiter #(
  parameter int                       DEPTH     = 4,
  parameter int                       MAX_WAIT  = 8,
  parameter logic [cpu_pkg::RF_AW-1:0] OPND1_REG = cpu_pkg::OPND1_REG,
  parameter logic [cpu_pkg::RF_AW-1:0] OPND2_REG = cpu_pkg::OPND2_REG
) (
  input  logic                clk,
  input  logic                rst_n,
  rf_write_arbiter_if.slave   bus
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]         stat_overruns,
  output logic [15:0]         stat_stalls
`endif
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] NEAR_FULL = CW'(DEPTH - 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

  logic          push, pop, full, empty;
  logic [7:0]    head;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic          flag_q, sig_q, ovr_q, drop;
  arb_state_t    state, state_nxt;

  // UART only gets the port when WB is idle
  assign push = bus.rx_valid;
  assign pop  = !bus.wb_we && !empty;
  assign drop = push && full && !pop;

  sync_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (bus.rx_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // write port mux, purely combinational
  always_comb begin
    bus.rf_we   = 1'b0;
    bus.rf_addr = '0;
    bus.rf_data = '0;
    if (bus.wb_we) begin
      bus.rf_we   = 1'b1;
      bus.rf_addr = bus.wb_addr;
      bus.rf_data = bus.wb_data;
    end else if (!empty) begin
      bus.rf_we   = 1'b1;
      bus.rf_addr = flag_q ? OPND2_REG : OPND1_REG;
      bus.rf_data = RF_DW'(head);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q   <= 1'b0;
      sig_q    <= 1'b0;
      ovr_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (pop) flag_q <= !flag_q;
      sig_q <= pop && flag_q;
      ovr_q <= drop;
      // only counts starved cycles: non-empty and no pop implies wb_we
      if (pop || empty)             wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!empty) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (empty)                                        state_nxt = ST_IDLE;
        else if (wait_cnt == WAIT_MAX || count >= NEAR_FULL) state_nxt = ST_STALL;
      end
      ST_STALL: if (empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign bus.uart_flag   = flag_q;
  assign bus.uart_signal = sig_q;
  assign bus.rx_overrun  = ovr_q;
  assign bus.stall_req   = (state == ST_STALL);

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_overruns <= '0;
      stat_stalls   <= '0;
    end else begin
      if (drop && stat_overruns != 16'hFFFF) stat_overruns <= stat_overruns + 1'b1;
      if (state == ST_WAIT && state_nxt == ST_STALL && stat_stalls != 16'hFFFF)
        stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif
endmodule
